tuple_writer: RTL

Flow-tuple source for the packet generator: walks a configured flow range and packet-length sweep, and writes one {five-tuple, packet length} entry per cycle into the downstream tuple queue's write port. It respects the queue's nearly-full back-pressure. It sits upstream of the tuple queue and is driven by the control-register block (start/stop plus static configuration).

---
 rtl/pktgen_pkg.sv | 24 ++
 rtl/tuple_writer_len_sweep.sv | 44 ++++
 rtl/tuple_writer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pktgen_pkg.sv
// Shared definitions for the packet generator.
// Holds the default datapath widths, the five-tuple field offsets and the tuple
// writer FSM state type.
// Five-tuple layout, MSB to LSB: src_ip[32], dst_ip[32], src_port[16],
// dst_port[16], proto[8].
package pktgen_pkg;

  localparam int unsigned DEF_TUPLE_WIDTH = 104;
  localparam int unsigned DEF_LEN_WIDTH   = 16;

  localparam int unsigned PORT_WIDTH   = 16;
  localparam int unsigned PROTO_LSB    = 0;
  localparam int unsigned DST_PORT_LSB = 8;
  localparam int unsigned SRC_PORT_LSB = 24;
  localparam int unsigned DST_IP_LSB   = 40;
  localparam int unsigned SRC_IP_LSB   = 72;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tw_state_e;

endpackage

// File: rtl/tuple_writer_len_sweep.sv
// Packet-length sweep register for the tuple writer.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   load             restart the sweep at len_min
//   advance          step to the next length
//   len_min/max/step sweep bounds and increment
//   cur_len          current length
// On advance the sum is formed one bit wider. A carry out, or a sum above
// len_max, wraps back to len_min. This also pins the length at len_min when
// len_max < len_min, and a zero step holds the length constant.
module tuple_writer_len_sweep
  import pktgen_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 advance,
  input  logic [LEN_WIDTH-1:0] len_min,
  input  logic [LEN_WIDTH-1:0] len_max,
  input  logic [LEN_WIDTH-1:0] len_step,
  output logic [LEN_WIDTH-1:0] cur_len
);

  logic [LEN_WIDTH:0] sum;

  assign sum = {1'b0, cur_len} + {1'b0, len_step};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_len <= '0;
    end else if (load) begin
      cur_len <= len_min;
    end else if (advance) begin
      if (sum[LEN_WIDTH] || (sum[LEN_WIDTH-1:0] > len_max)) begin
        cur_len <= len_min;
      end else begin
        cur_len <= sum[LEN_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/tuple_writer.sv
// Flow-tuple source: walks a flow range and length sweep, and writes one
// {five-tuple, length} entry per cycle into the tuple queue.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, stop       run control pulses
//   cfg_*             static configuration, latched on start
//   fifo_data_out     {tuple, len} write data (registered)
//   fifo_wr_en        write strobe (registered)
//   fifo_nearly_full  queue back-pressure
//   busy, done        high in RUN / DONE
//   pkt_sent_cnt      entries written in the current or last run
// Build option: define TUPLE_WRITER_STATS_EN to implement pkt_sent_cnt;
// otherwise it reads 0. Completion always uses an internal down-counter.
module tuple_writer
  import pktgen_pkg::*;
#(
  parameter int unsigned PKT_TUPLE_WIDTH = DEF_TUPLE_WIDTH,
  parameter int unsigned PKT_LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int unsigned FLOW_CNT_WIDTH  = 16,
  parameter int unsigned PKT_CNT_WIDTH   = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic [PKT_TUPLE_WIDTH-1:0]             cfg_base_tuple,
  input  logic [FLOW_CNT_WIDTH-1:0]              cfg_flow_num,
  input  logic [PKT_LEN_WIDTH-1:0]               cfg_len_min,
  input  logic [PKT_LEN_WIDTH-1:0]               cfg_len_max,
  input  logic [PKT_LEN_WIDTH-1:0]               cfg_len_step,
  input  logic [PKT_CNT_WIDTH-1:0]               cfg_pkt_total,
  output logic [PKT_TUPLE_WIDTH+PKT_LEN_WIDTH-1:0] fifo_data_out,
  output logic                                   fifo_wr_en,
  input  logic                                   fifo_nearly_full,
  output logic                                   busy,
  output logic                                   done,
  output logic [PKT_CNT_WIDTH-1:0]               pkt_sent_cnt
);

  tw_state_e                  state_q;
  logic [PKT_TUPLE_WIDTH-1:0] base_q;
  logic [FLOW_CNT_WIDTH-1:0]  flow_last_q;
  logic [FLOW_CNT_WIDTH-1:0]  flow_idx_q;
  logic [PKT_LEN_WIDTH-1:0]   len_min_q;
  logic [PKT_LEN_WIDTH-1:0]   len_max_q;
  logic [PKT_LEN_WIDTH-1:0]   len_step_q;
  logic [PKT_CNT_WIDTH-1:0]   remain_q;
  logic                       unlimited_q;

  logic                       start_ok;
  logic                       write_ok;
  logic                       flow_wrap;
  logic                       last_write;
  logic [PKT_TUPLE_WIDTH-1:0] tuple_cur;
  logic [PKT_LEN_WIDTH-1:0]   cur_len;

  // Start is honoured in IDLE unless stop arrives with it; in DONE stop is ignored.
  assign start_ok   = start && (((state_q == IDLE) && !stop) || (state_q == DONE));
  // Stop wins over a write in the same cycle.
  assign write_ok   = (state_q == RUN) && !stop && !fifo_nearly_full;
  assign flow_wrap  = (flow_idx_q == flow_last_q);
  assign last_write = write_ok && !unlimited_q && (remain_q == PKT_CNT_WIDTH'(1));

  always_comb begin
    tuple_cur = base_q;
    tuple_cur[SRC_PORT_LSB +: PORT_WIDTH] =
      base_q[SRC_PORT_LSB +: PORT_WIDTH] + PORT_WIDTH'(flow_idx_q);
  end

  tuple_writer_len_sweep #(
    .LEN_WIDTH (PKT_LEN_WIDTH)
  ) u_len_sweep (
    .clk      (clk),
    .reset    (reset),
    .load     (start_ok),
    .advance  (write_ok && flow_wrap),
    .len_min  (start_ok ? cfg_len_min : len_min_q),
    .len_max  (len_max_q),
    .len_step (len_step_q),
    .cur_len  (cur_len)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      fifo_wr_en    <= 1'b0;
      fifo_data_out <= '0;
      base_q        <= '0;
      flow_last_q   <= '0;
      flow_idx_q    <= '0;
      len_min_q     <= '0;
      len_max_q     <= '0;
      len_step_q    <= '0;
      remain_q      <= '0;
      unlimited_q   <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (start_ok) begin
        state_q     <= RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        base_q      <= cfg_base_tuple;
        // A flow count of 0 behaves as a single flow.
        flow_last_q <= (cfg_flow_num == '0) ? '0 : cfg_flow_num - FLOW_CNT_WIDTH'(1);
        flow_idx_q  <= '0;
        len_min_q   <= cfg_len_min;
        len_max_q   <= cfg_len_max;
        len_step_q  <= cfg_len_step;
        remain_q    <= cfg_pkt_total;
        unlimited_q <= (cfg_pkt_total == '0);
      end else if (state_q == RUN) begin
        if (stop) begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end else if (write_ok) begin
          fifo_wr_en    <= 1'b1;
          fifo_data_out <= {tuple_cur, cur_len};
          flow_idx_q    <= flow_wrap ? '0 : flow_idx_q + FLOW_CNT_WIDTH'(1);
          remain_q      <= remain_q - PKT_CNT_WIDTH'(1);
          if (last_write) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
      end else if ((state_q != IDLE) && (state_q != DONE)) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
      end
    end
  end

`ifdef TUPLE_WRITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_sent_cnt <= '0;
    end else if (start_ok) begin
      pkt_sent_cnt <= '0;
    end else if (write_ok && (pkt_sent_cnt != '1)) begin
      pkt_sent_cnt <= pkt_sent_cnt + PKT_CNT_WIDTH'(1);
    end
  end
`else
  assign pkt_sent_cnt = '0;
`endif

endmodule
